fir_sym_sched: RTL and testbench

FIR_SYM_SCHED -- requirements
Module: fir_sym_sched

---
 rtl/fir_sym_sched_pkg.sv | 27 ++
 rtl/fir_sym_sched_mac.sv | 43 ++++
 rtl/fir_sym_sched.sv | 143 ++++++++++++++
 tb/tb_fir_sym_sched.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_sym_sched_pkg.sv
// Shared state encoding and width derivations for the symmetric FIR scheduler.
package fir_sym_sched_pkg;

  // FSM state encoding
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_OUT   = 2'd3;

  // Number of stored coefficients for a symmetric filter of the given length
  function automatic int unsigned half_of(input int unsigned taps);
    return taps / 2;
  endfunction

  // Result / accumulator width
  function automatic int unsigned out_bits_of(input int unsigned data_bits,
                                              input int unsigned coef_bits,
                                              input int unsigned extend_bits);
    return data_bits + coef_bits + extend_bits;
  endfunction

  // Coefficient index width, never below one bit
  function automatic int unsigned addr_bits_of(input int unsigned taps);
    return (taps / 2 > 1) ? $clog2(taps / 2) : 1;
  endfunction

endpackage

// File: rtl/fir_sym_sched_mac.sv
// Pre-add MAC: result = (a + b) * coef, registered, one cycle latency.
module fir_base
  import fir_sym_sched_pkg::*;
#(
  parameter int unsigned DATA_BITS   = 16,
  parameter int unsigned COEF_BITS   = 16,
  parameter int unsigned EXTEND_BITS = 5
) (
  input  logic                                                       clk,
  input  logic                                                       rst,
  input  logic                                                       en,
  input  logic signed [DATA_BITS-1:0]                                a_data,
  input  logic signed [DATA_BITS-1:0]                                b_data,
  input  logic signed [COEF_BITS-1:0]                                coef,
  output logic                                                       output_vld,
  output logic signed [out_bits_of(DATA_BITS, COEF_BITS, EXTEND_BITS)-1:0] result
);

  localparam int unsigned SUM_BITS  = DATA_BITS + 1;
  localparam int unsigned PROD_BITS = DATA_BITS + COEF_BITS + 1;
  localparam int unsigned RES_BITS  = out_bits_of(DATA_BITS, COEF_BITS, EXTEND_BITS);

  logic signed [SUM_BITS-1:0]  sum_c;
  logic signed [PROD_BITS-1:0] prod_c;

  // Symmetric pre-add followed by the multiply
  always_comb begin
    sum_c  = SUM_BITS'(a_data) + SUM_BITS'(b_data);
    prod_c = PROD_BITS'(sum_c) * PROD_BITS'(coef);
  end

  // Result register and its valid flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      output_vld <= 1'b0;
      result     <= '0;
    end else begin
      output_vld <= en;
      if (en) result <= RES_BITS'(prod_c);
    end
  end

endmodule

// File: rtl/fir_sym_sched.sv
// Symmetric FIR filter, one sample at a time, folded onto a single pre-add MAC.
module fir_sym_sched
  import fir_sym_sched_pkg::*;
#(
  parameter int unsigned DATA_BITS   = 16,
  parameter int unsigned COEF_BITS   = 16,
  parameter int unsigned EXTEND_BITS = 5,
  parameter int unsigned TAPS        = 8,
  parameter int unsigned OUT_BITS    = out_bits_of(DATA_BITS, COEF_BITS, EXTEND_BITS)
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                in_valid,
  input  logic signed [DATA_BITS-1:0]         in_data,
  output logic                                in_ready,
  output logic                                out_valid,
  output logic signed [OUT_BITS-1:0]          out_data,
  input  logic                                out_ready,
  input  logic                                coef_we,
  input  logic [addr_bits_of(TAPS)-1:0]       coef_addr,
  input  logic signed [COEF_BITS-1:0]         coef_wdata,
  output logic                                busy
);

  localparam int unsigned HALF     = half_of(TAPS);
  localparam int unsigned ADDR_W   = addr_bits_of(TAPS);
  localparam int unsigned MAC_BITS = out_bits_of(DATA_BITS, COEF_BITS, EXTEND_BITS);

  logic [1:0]                  state_q, state_n;
  logic [ADDR_W-1:0]           k_q;
  logic signed [DATA_BITS-1:0] x_q [TAPS];
  logic signed [COEF_BITS-1:0] h_q [HALF];
  logic signed [OUT_BITS-1:0]  acc_q;
  logic                        in_ready_q, out_valid_q, busy_q;

  logic                        accept_c, coef_wr_c, addr_ok_c, k_last_c, mac_en_c;
  logic signed [DATA_BITS-1:0] mac_a_c, mac_b_c;
  logic signed [COEF_BITS-1:0] mac_coef_c;
  logic                        mac_vld;
  logic signed [MAC_BITS-1:0]  mac_res;

  // Coefficient index range check only exists when the port can exceed HALF-1
  if ((1 << ADDR_W) > HALF) begin : g_addr_chk
    assign addr_ok_c = (coef_addr < ADDR_W'(HALF));
  end else begin : g_addr_all
    assign addr_ok_c = 1'b1;
  end

  assign accept_c  = in_valid && in_ready_q && (state_q == ST_IDLE);
  assign coef_wr_c = coef_we && (state_q == ST_IDLE) && addr_ok_c;
  assign k_last_c  = (k_q == ADDR_W'(HALF - 1));

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_n;
  end

  // Next-state and MAC enable
  always_comb begin
    state_n  = state_q;
    mac_en_c = 1'b0;
    case (state_q)
      ST_IDLE:  if (accept_c) state_n = ST_RUN;
      ST_RUN: begin
        mac_en_c = 1'b1;
        if (k_last_c) state_n = ST_DRAIN;
      end
      ST_DRAIN: state_n = ST_OUT;
      ST_OUT:   if (out_ready) state_n = ST_IDLE;
      default:  state_n = ST_IDLE;
    endcase
  end

  // Handshake and status flags registered from the next state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      in_ready_q  <= (state_n == ST_IDLE);
      out_valid_q <= (state_n == ST_OUT);
      busy_q      <= (state_n != ST_IDLE);
    end
  end

  // Select the symmetric tap pair and coefficient for index k
  always_comb begin
    mac_a_c    = '0;
    mac_b_c    = '0;
    mac_coef_c = '0;
    for (int i = 0; i < int'(HALF); i++) begin
      if (k_q == ADDR_W'(i)) begin
        mac_a_c    = x_q[i];
        mac_b_c    = x_q[int'(TAPS) - 1 - i];
        mac_coef_c = h_q[i];
      end
    end
  end

  // Delay line, coefficient store, tap index and accumulator
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      k_q   <= '0;
      acc_q <= '0;
      for (int i = 0; i < int'(TAPS); i++) x_q[i] <= '0;
      for (int i = 0; i < int'(HALF); i++) h_q[i] <= '0;
    end else begin
      if (coef_wr_c) h_q[coef_addr] <= coef_wdata;
      if (accept_c) begin
        x_q[0] <= in_data;
        for (int i = 1; i < int'(TAPS); i++) x_q[i] <= x_q[i-1];
        k_q   <= '0;
        acc_q <= '0;
      end else begin
        if (state_q == ST_RUN) k_q <= k_q + ADDR_W'(1);
        if (mac_vld) acc_q <= acc_q + OUT_BITS'(mac_res);
      end
    end
  end

  fir_base #(
    .DATA_BITS   (DATA_BITS),
    .COEF_BITS   (COEF_BITS),
    .EXTEND_BITS (EXTEND_BITS)
  ) u_mac (
    .clk        (clk),
    .rst        (rst),
    .en         (mac_en_c),
    .a_data     (mac_a_c),
    .b_data     (mac_b_c),
    .coef       (mac_coef_c),
    .output_vld (mac_vld),
    .result     (mac_res)
  );

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = acc_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_fir_sym_sched.sv
// Scoreboard bench for fir_sym_sched: directed corner cases plus random traffic.
module tb_fir_sym_sched;

  localparam int DW   = 16;
  localparam int CW   = 16;
  localparam int EW   = 5;
  localparam int TAPS = 8;
  localparam int HALF = 4;
  localparam int AW   = 2;
  localparam int OW   = DW + CW + EW;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic [OW-1:0] out_data;
  logic          out_ready = 1'b0;
  logic          coef_we;
  logic [AW-1:0] coef_addr;
  logic [CW-1:0] coef_wdata;
  logic          busy;

  int     n_checks = 0;
  int     n_fail   = 0;
  longint exp_q[$];
  longint mh[HALF];
  longint xh[TAPS];
  bit     random_bp   = 1'b0;
  bit     ready_force = 1'b1;

  always #5 clk = ~clk;

  fir_sym_sched #(
    .DATA_BITS(DW), .COEF_BITS(CW), .EXTEND_BITS(EW), .TAPS(TAPS), .OUT_BITS(OW)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata),
    .busy(busy)
  );

  task automatic check(input string name, input longint got, input longint exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: timed out (t=%0t)", name, $time);
  endtask

  function automatic longint wrap_out(input longint v);
    logic [OW-1:0] t;
    t = v[OW-1:0];
    return longint'($signed(t));
  endfunction

  // Reference: y = sum over all taps of h_full[i] * x[n-i], h_full mirrored
  function automatic longint model_push(input longint s);
    longint acc;
    int     k;
    for (int i = TAPS - 1; i > 0; i--) xh[i] = xh[i-1];
    xh[0] = s;
    acc = 0;
    for (int i = 0; i < TAPS; i++) begin
      k = (i < HALF) ? i : TAPS - 1 - i;
      acc += mh[k] * xh[i];
    end
    return wrap_out(acc);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < HALF; i++) mh[i] = 0;
    for (int i = 0; i < TAPS; i++) xh[i] = 0;
    exp_q.delete();
  endtask

  // out_ready driver: random or forced level, changed just after the edge
  always @(posedge clk) begin
    #2;
    out_ready = random_bp ? 1'($urandom_range(0, 1)) : ready_force;
  end

  // Monitor: pops expected results on output handshakes and checks hold stability
  logic [OW-1:0] prev_data;
  bit            prev_stall = 1'b0;
  always @(negedge clk) begin
    if (!rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_out_valid", longint'(out_valid), 1);
        check("hold_out_data", longint'($signed(out_data)), longint'($signed(prev_data)));
        check("hold_in_ready", longint'(in_ready), 0);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_output: got %0d with no result pending", $signed(out_data));
        end else begin
          check("out_data", longint'($signed(out_data)), exp_q.pop_front());
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
    end
  end

  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        return;
      end
    end
    timeout_fail("wait_in_ready");
  endtask

  task automatic send(input longint d, input bit we, input int addr, input longint wd,
                      input bit ovr, input longint ovr_val);
    bit     ok;
    longint e;
    wait_ready(ok);
    if (!ok) return;
    in_valid = 1'b1;
    in_data  = DW'(d);
    if (we) begin
      coef_we    = 1'b1;
      coef_addr  = AW'(addr);
      coef_wdata = CW'(wd);
    end
    @(posedge clk);
    if (we) mh[addr] = wd;
    e = model_push(d);
    exp_q.push_back(ovr ? ovr_val : e);
    #1;
    in_valid = 1'b0;
    coef_we  = 1'b0;
  endtask

  task automatic write_coef(input int addr, input longint wd);
    bit ok;
    wait_ready(ok);
    if (!ok) return;
    coef_we    = 1'b1;
    coef_addr  = AW'(addr);
    coef_wdata = CW'(wd);
    @(posedge clk);
    mh[addr] = wd;
    #1 coef_we = 1'b0;
  endtask

  task automatic wait_drain();
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && in_ready) return;
    end
    timeout_fail("drain");
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    coef_we  = 1'b0;
    rst      = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  // Watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    longint        imp[8];
    logic [OW-1:0] held;
    bit            seen;
    logic [DW-1:0] rd;
    logic [CW-1:0] rc;

    imp = '{1, 2, 3, 4, 4, 3, 2, 1};
    rst = 1'b0; in_valid = 1'b0; in_data = '0;
    coef_we = 1'b0; coef_addr = '0; coef_wdata = '0;
    model_reset();

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_in_ready", longint'(in_ready), 0);
    check("rst_out_valid", longint'(out_valid), 0);
    check("rst_busy", longint'(busy), 0);
    check("rst_out_data", longint'($signed(out_data)), 0);
    rst = 1'b1;
    @(negedge clk);
    check("in_ready_after_reset", longint'(in_ready), 1);

    // Impulse response
    for (int i = 0; i < HALF; i++) write_coef(i, i + 1);
    for (int i = 0; i < 8; i++) send((i == 0) ? 1 : 0, 1'b0, 0, 0, 1'b1, imp[i]);
    wait_drain();

    // Latency and busy window
    send(100, 1'b0, 0, 0, 1'b0, 0);
    for (int j = 1; j <= HALF + 2; j++) begin
      @(negedge clk);
      check("lat_busy", longint'(busy), 1);
      check("lat_out_valid", longint'(out_valid), (j == HALF + 2) ? 1 : 0);
    end
    wait_drain();

    // Backpressure hold
    ready_force = 1'b0;
    send(-1234, 1'b0, 0, 0, 1'b0, 0);
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    if (!seen) timeout_fail("bp_out_valid");
    held = out_data;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("bp_valid", longint'(out_valid), 1);
      check("bp_in_ready", longint'(in_ready), 0);
      check("bp_data", longint'($signed(out_data)), longint'($signed(held)));
    end
    ready_force = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("bp_handshake_ready", longint'(out_ready), 1);
    @(negedge clk);
    check("bp_idle_in_ready", longint'(in_ready), 1);
    check("bp_idle_busy", longint'(busy), 0);
    wait_drain();

    // Negative full scale
    do_reset();
    for (int i = 0; i < HALF; i++) write_coef(i, 1);
    for (int i = 0; i < 8; i++) send(-32768, 1'b0, 0, 0, (i == 7), -262144);
    wait_drain();

    // Reset while running at k=2 abandons the sample
    write_coef(0, 1);
    send(777, 1'b0, 0, 0, 1'b0, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_run_out_valid", longint'(out_valid), 0);
    check("rst_run_busy", longint'(busy), 0);
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    write_coef(0, 1);
    send(5, 1'b0, 0, 0, 1'b1, 5);
    wait_drain();

    // Coefficient lockout while busy, then a legal write in IDLE
    send(11, 1'b0, 0, 0, 1'b0, 0);
    repeat (2) @(negedge clk);
    coef_we = 1'b1; coef_addr = '0; coef_wdata = CW'(7);
    @(posedge clk);
    #1 coef_we = 1'b0;
    wait_drain();
    send(2, 1'b0, 0, 0, 1'b0, 0);
    wait_drain();
    write_coef(0, 7);
    send(3, 1'b0, 0, 0, 1'b0, 0);
    wait_drain();

    // Random traffic with backpressure and same-cycle coefficient writes
    random_bp = 1'b1;
    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        rc = CW'($urandom);
        write_coef(int'($urandom_range(0, HALF - 1)), longint'($signed(rc)));
      end
      rd = DW'($urandom);
      rc = CW'($urandom);
      send(longint'($signed(rd)), ($urandom_range(0, 3) == 0),
           int'($urandom_range(0, HALF - 1)), longint'($signed(rc)), 1'b0, 0);
    end
    wait_drain();
    random_bp = 1'b0;
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
